operand_stack: RTL

Synchronous LIFO operand stack for the 8-bit stack-machine CPU. It sits directly downstream of the CPU control unit and consumes that unit's `push`, `pop` and `data_to_push` strobes. It returns the top-of-stack (TOS) value on `data_from_stack` for ALU operand fetch and POP-to-RAM. It also adds full/empty status and sticky overflow/underflow error reporting, which the control unit can use to trap stack faults.

---
 rtl/operand_stack_pkg.sv | 15 +
 rtl/operand_stack_if.sv | 42 ++++
 rtl/operand_stack_regfile.sv | 27 ++
 rtl/operand_stack.sv | 118 +++++++++++
 4 files changed

// File: rtl/operand_stack_pkg.sv
// Shared stack-machine CPU definitions: status-state encodings
// and default operand-stack geometry.
package operand_stack_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2,
    ST_ERROR  = 2'd3
  } st_e;

endpackage

// File: rtl/operand_stack_if.sv
// Control-unit <-> operand stack bundle: push/pop/clear_err strobes in,
// TOS, count, full/empty, sticky overflow/underflow (and nos) out.
interface operand_stack_if #(
  parameter int WIDTH = operand_stack_pkg::DEF_WIDTH,
  parameter int PTR_W = $clog2(operand_stack_pkg::DEF_DEPTH)
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_to_push;
  logic             clear_err;
  logic [WIDTH-1:0] data_from_stack;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
`ifdef OPERAND_STACK_NOS_EN
  logic [WIDTH-1:0] nos;

  modport master (
    output push, pop, data_to_push, clear_err,
    input  data_from_stack, count, empty, full,
    input  overflow, underflow, nos
  );
  modport slave (
    input  push, pop, data_to_push, clear_err,
    output data_from_stack, count, empty, full,
    output overflow, underflow, nos
  );
`else
  modport master (
    output push, pop, data_to_push, clear_err,
    input  data_from_stack, count, empty, full,
    input  overflow, underflow
  );
  modport slave (
    input  push, pop, data_to_push, clear_err,
    output data_from_stack, count, empty, full,
    output overflow, underflow
  );
`endif
endinterface

// File: rtl/operand_stack_regfile.sv
// DEPTH x WIDTH stack storage: one synchronous write port,
// combinational TOS and NOS read ports. Contents are never reset.
module stack_regfile #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] tos_addr,
  input  logic [PTR_W-1:0] nos_addr,
  output logic [WIDTH-1:0] tos_q,
  output logic [WIDTH-1:0] nos_q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign tos_q = mem[tos_addr];
  assign nos_q = mem[nos_addr];

endmodule

// File: rtl/operand_stack.sv
// LIFO operand stack with status FSM and sticky fault flags.
// Ports: clk, reset (sync, active-high), bus (operand_stack_if.slave).
// Optional: OPERAND_STACK_NOS_EN adds the next-of-stack output.
module operand_stack
  import operand_stack_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           reset,
  operand_stack_if.slave bus
);

  localparam logic [PTR_W:0] SP_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] SP_ONE = (PTR_W+1)'(1);

  logic [PTR_W:0]   sp, sp_n;
  st_e              state, lvl;
  logic             is_empty, is_full;
  logic             do_rep, do_push, do_ovf;
  logic             do_pop, do_unf;
  logic             we;
  logic [PTR_W-1:0] waddr, tos_a, nos_a;
  logic [WIDTH-1:0] tos_q, nos_q;
  logic             ov_q, un_q;

  assign is_empty = (sp == '0);
  assign is_full  = (sp == SP_MAX);

  // At sp == DEPTH the low bits wrap to 0, so -1 still lands on DEPTH-1.
  assign tos_a = sp[PTR_W-1:0] - PTR_W'(1);
  assign nos_a = sp[PTR_W-1:0] - PTR_W'(2);

  // Mutually exclusive op decode; push+pop on empty is a plain push.
  assign do_rep  = bus.push & bus.pop & ~is_empty;
  assign do_push = bus.push & ~do_rep & ~is_full;
  assign do_ovf  = bus.push & ~do_rep & is_full;
  assign do_pop  = bus.pop & ~bus.push & ~is_empty;
  assign do_unf  = bus.pop & ~bus.push & is_empty;

  always_comb begin
    we    = 1'b0;
    waddr = sp[PTR_W-1:0];
    sp_n  = sp;
    unique case (1'b1)
      do_rep: begin
        we    = 1'b1;
        waddr = tos_a;
      end
      do_push: begin
        we   = 1'b1;
        sp_n = sp + SP_ONE;
      end
      do_pop:  sp_n = sp - SP_ONE;
      default: ;
    endcase
  end

  always_comb begin
    lvl = ST_ACTIVE;
    if (sp_n == '0)
      lvl = ST_EMPTY;
    else if (sp_n == SP_MAX)
      lvl = ST_FULL;
  end

  // A fresh fault in the clear_err cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp    <= '0;
      ov_q  <= 1'b0;
      un_q  <= 1'b0;
      state <= ST_EMPTY;
    end else begin
      sp   <= sp_n;
      ov_q <= (ov_q & ~bus.clear_err) | do_ovf;
      un_q <= (un_q & ~bus.clear_err) | do_unf;
      if (do_ovf | do_unf)
        state <= ST_ERROR;
      else if (state == ST_ERROR && !bus.clear_err)
        state <= ST_ERROR;
      else
        state <= lvl;
    end
  end

  stack_regfile #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .PTR_W (PTR_W)
  ) u_rf (
    .clk      (clk),
    .we       (we),
    .waddr    (waddr),
    .wdata    (bus.data_to_push),
    .tos_addr (tos_a),
    .nos_addr (nos_a),
    .tos_q    (tos_q),
    .nos_q    (nos_q)
  );

  assign bus.data_from_stack = is_empty ? '0 : tos_q;
  assign bus.count           = sp;
  assign bus.empty           = is_empty;
  assign bus.full            = is_full;
  assign bus.overflow        = ov_q;
  assign bus.underflow       = un_q;

`ifdef OPERAND_STACK_NOS_EN
  assign bus.nos = (sp >= (PTR_W+1)'(2)) ? nos_q : '0;
`else
  logic unused_nos;
  assign unused_nos = ^nos_q;
`endif

endmodule
